// File: rtl/warp_regfile.sv
// warp_regfile: per-warp register contexts with multi-port 1-cycle reads, one write port
// and a sequencer that clears and seeds one warp's context on request.
module warp_regfile #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 3,
    localparam int WW = $clog2(NUM_WARPS),
    localparam int RW = $clog2(NUM_REGS)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_RD_PORTS-1:0]                   rd_en,
    input  logic [NUM_RD_PORTS-1:0][WW-1:0]           rd_warp,
    input  logic [NUM_RD_PORTS-1:0][RW-1:0]           rd_addr,
    output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD_PORTS-1:0]                   rd_valid,
    input  logic                                      wr_en,
    input  logic [WW-1:0]                             wr_warp,
    input  logic [RW-1:0]                             wr_addr,
    input  logic [DATA_WIDTH-1:0]                     wr_data,
    input  logic                                      init_req,
    input  logic [WW-1:0]                             init_warp,
    input  logic [DATA_WIDTH-1:0]                     thread_idx,
    input  logic [DATA_WIDTH-1:0]                     block_idx,
    input  logic [DATA_WIDTH-1:0]                     block_dim,
    input  logic [DATA_WIDTH-1:0]                     grid_dim,
    input  logic [DATA_WIDTH-1:0]                     lane_idx,
    output logic                                      init_busy,
    output logic                                      init_done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic [RW-1:0]         cnt;
    logic [WW-1:0]         iwarp;
    logic [DATA_WIDTH-1:0] c_tid, c_bid, c_bdim, c_gdim, c_lane;
    logic [DATA_WIDTH-1:0] mem [NUM_WARPS][NUM_REGS];
    logic                  wr_ok;

    assign init_busy = state == CLEAR || state == LOAD;
    assign init_done = state == DONE;
    // x0 is hard zero; the warp owned by the sequencer is closed to external writes
    assign wr_ok = wr_en && wr_addr != '0 && !(init_busy && wr_warp == iwarp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            iwarp  <= '0;
            c_tid  <= '0;
            c_bid  <= '0;
            c_bdim <= '0;
            c_gdim <= '0;
            c_lane <= '0;
        end else begin
            case (state)
                IDLE: if (init_req) begin
                    state  <= CLEAR;
                    cnt    <= '0;
                    iwarp  <= init_warp;
                    c_tid  <= thread_idx;
                    c_bid  <= block_idx;
                    c_bdim <= block_dim;
                    c_gdim <= grid_dim;
                    c_lane <= lane_idx;
                end
                CLEAR: begin
                    cnt   <= cnt + 1'b1;
                    state <= cnt == RW'(NUM_REGS - 1) ? LOAD : CLEAR;
                end
                LOAD:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++)
                for (int r = 0; r < NUM_REGS; r++)
                    mem[w][r] <= '0;
        end else begin
            if (wr_ok)
                mem[wr_warp][wr_addr] <= wr_data;
            if (state == CLEAR && cnt != '0)
                mem[iwarp][cnt] <= '0;
            if (state == LOAD) begin
                mem[iwarp][1] <= c_tid;
                mem[iwarp][2] <= c_bid;
                mem[iwarp][3] <= c_bdim;
                mem[iwarp][4] <= c_gdim;
                mem[iwarp][5] <= DATA_WIDTH'(iwarp);
                mem[iwarp][6] <= c_lane;
            end
        end
    end

    // same-cycle external write is forwarded so readers never see stale data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                rd_valid[p] <= rd_en[p];
                if (rd_en[p])
                    rd_data[p] <= (wr_ok && wr_warp == rd_warp[p] && wr_addr == rd_addr[p])
                                  ? wr_data : mem[rd_warp[p]][rd_addr[p]];
            end
        end
    end
endmodule

// File: tb/tb_warp_regfile.sv
// tb_warp_regfile: scoreboard bench for warp_regfile; read expectations are queued when
// a read is driven and compared when the registered result appears.
module tb_warp_regfile;
    typedef struct {
        int          port;
        logic [31:0] exp;
        int          cyc;
        int          id;
    } rd_t;

    logic            clk = 0;
    logic            rst_n;
    logic [2:0]      rd_en;
    logic [2:0][1:0] rd_warp;
    logic [2:0][4:0] rd_addr;
    logic [2:0][31:0] rd_data;
    logic [2:0]      rd_valid;
    logic            wr_en;
    logic [1:0]      wr_warp;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_data;
    logic            init_req;
    logic [1:0]      init_warp;
    logic [31:0]     thread_idx, block_idx, block_dim, grid_dim, lane_idx;
    logic            init_busy, init_done;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          nid = 0;
    rd_t         sb[$];
    rd_t         e;
    logic [31:0] mdl [4][32];
    int          ws[8], as[8];
    logic        done_seen, busy_seen;

    warp_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_warp(rd_warp), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_warp(wr_warp), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_req(init_req), .init_warp(init_warp),
        .thread_idx(thread_idx), .block_idx(block_idx), .block_dim(block_dim),
        .grid_dim(grid_dim), .lane_idx(lane_idx),
        .init_busy(init_busy), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        rd_en = '0;
        wr_en = 0;
        init_req = 0;
    endtask

    task automatic wr(input int w, input int a, input logic [31:0] d);
        wr_en = 1;
        wr_warp = w[1:0];
        wr_addr = a[4:0];
        wr_data = d;
    endtask

    task automatic rd(input int p, input int w, input int a, input logic [31:0] exp);
        rd_en[p] = 1;
        rd_warp[p] = w[1:0];
        rd_addr[p] = a[4:0];
        sb.push_back('{p, exp, cyc, nid});
        nid++;
    endtask

    // results of reads driven in cycle cyc are visible just after the next rising edge
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk($sformatf("rd%0d_p%0d_data", e.id, e.port), rd_data[e.port], e.exp);
            chk($sformatf("rd%0d_p%0d_valid", e.id, e.port), 32'(rd_valid[e.port]), 32'd1);
        end
        cyc++;
    end

    initial begin
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 32; r++)
                mdl[w][r] = '0;
        rst_n = 0;
        rd_en = '0; rd_warp = '0; rd_addr = '0;
        wr_en = 0; wr_warp = '0; wr_addr = '0; wr_data = '0;
        init_req = 0; init_warp = '0;
        thread_idx = '0; block_idx = '0; block_dim = '0; grid_dim = '0; lane_idx = '0;
        repeat (2) step();
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data0", rd_data[0], 32'd0);
        chk("rst_busy", 32'(init_busy), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        rst_n = 1;

        step(); wr(2, 7, 32'hDEADBEEF); mdl[2][7] = 32'hDEADBEEF;
        step(); rd(1, 2, 7, 32'hDEADBEEF);
        step();
        step();
        chk("idle_valid1", 32'(rd_valid[1]), 32'd0);
        chk("idle_hold1", rd_data[1], 32'hDEADBEEF);

        step(); wr(0, 0, 32'h1234); rd(0, 0, 0, 32'd0);
        step(); wr(1, 5, 32'hA5A5A5A5); rd(2, 1, 5, 32'hA5A5A5A5); mdl[1][5] = 32'hA5A5A5A5;
        step(); rd(0, 1, 5, 32'hA5A5A5A5); rd(1, 0, 0, 32'd0);
        step(); rd(0, 2, 7, 32'hDEADBEEF); rd(1, 2, 7, 32'hDEADBEEF); rd(2, 2, 7, 32'hDEADBEEF);

        for (int k = 0; k < 8; k++) begin
            logic [31:0] d;
            ws[k] = $urandom_range(0, 2);
            as[k] = $urandom_range(1, 31);
            d = $urandom;
            step(); wr(ws[k], as[k], d);
            mdl[ws[k]][as[k]] = d;
        end
        for (int k = 0; k < 8; k++) begin
            step(); rd(k % 3, ws[k], as[k], mdl[ws[k]][as[k]]);
        end

        step(); wr(3, 9, 32'h99);
        step(); wr(3, 31, 32'h3131);
        step(); wr(3, 1, 32'h1111);
        step();
        init_req = 1; init_warp = 3;
        thread_idx = 17; block_idx = 32'h22; block_dim = 32'h40; grid_dim = 32'h8; lane_idx = 1;
        for (int i = 1; i <= 36; i++) begin
            step();
            chk($sformatf("busy_c%0d", i), 32'(init_busy), 32'(i <= 33));
            chk($sformatf("done_c%0d", i), 32'(init_done), 32'(i == 34));
            if (i == 1) begin
                init_req = 1; init_warp = 1; thread_idx = 99; lane_idx = 77;
            end
            if (i == 5) rd(0, 3, 31, 32'h3131);
            if (i == 10) rd(1, 3, 1, 32'd0);
            if (i == 20) wr(3, 9, 5);
            if (i == 21) begin
                wr(0, 9, 6); mdl[0][9] = 6;
            end
        end
        step(); rd(0, 3, 1, 32'd17); rd(1, 3, 2, 32'h22); rd(2, 3, 3, 32'h40);
        step(); rd(0, 3, 4, 32'h8); rd(1, 3, 5, 32'd3); rd(2, 3, 6, 32'd1);
        step(); rd(0, 3, 0, 32'd0); rd(1, 0, 9, mdl[0][9]); rd(2, 1, 5, mdl[1][5]);
        for (int a = 7; a < 32; a += 3) begin
            step();
            for (int p = 0; p < 3; p++)
                if (a + p < 32) rd(p, 3, a + p, 32'd0);
        end

        step(); init_req = 1; init_warp = 0; thread_idx = 5;
        repeat (5) step();
        rst_n = 0;
        #1;
        chk("arst_busy", 32'(init_busy), 32'd0);
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_data0", rd_data[0], 32'd0);
        chk("arst_data1", rd_data[1], 32'd0);
        repeat (2) step();
        rst_n = 1;
        done_seen = 0;
        busy_seen = 0;
        repeat (40) begin
            step();
            done_seen |= init_done;
            busy_seen |= init_busy;
        end
        chk("post_rst_done", 32'(done_seen), 32'd0);
        chk("post_rst_busy", 32'(busy_seen), 32'd0);
        step(); rd(0, 2, 7, 32'd0); rd(1, 1, 5, 32'd0); rd(2, 3, 1, 32'd0);
        step(); rd(0, 0, 9, 32'd0); rd(1, 3, 5, 32'd0); rd(2, 0, 1, 32'd0);
        repeat (3) step();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
